// File: rtl/alu_op_sequencer.sv
// Opcode stimulus sequencer for the processor's switch port: steps in_switch through
// 0..N_OPS-1, captures final_output once per hold window, and exposes a 16-entry result buffer.
module alu_op_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 24,
  parameter int unsigned SAMPLE_OFFSET = 20,
  parameter int unsigned N_OPS         = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  final_output,
  input  logic [3:0]  rd_addr,
  output logic        select_input,
  output logic [3:0]  in_switch,
  output logic [3:0]  rd_data,
  output logic [15:0] valid,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] LAST_CNT   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SAMPLE_CNT = 8'(SAMPLE_OFFSET);
  localparam logic [3:0] LAST_OP    = 4'(N_OPS - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  op_idx_q, op_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] valid_q, valid_d;
  logic        cap_en;
  logic [3:0]  result_q [16];
  logic [3:0]  rd_data_q;
  logic        sel_q, sel_d;
  logic [3:0]  sw_q, sw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    op_idx_d = op_idx_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    cap_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          valid_d  = '0;
          op_idx_d = '0;
          cnt_d    = '0;
          state_d  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (cnt_q == SAMPLE_CNT) begin
          cap_en           = 1'b1;
          valid_d[op_idx_q] = 1'b1;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (op_idx_q == LAST_OP) state_d = ST_DONE;
          else                     op_idx_d = op_idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        // Abort overrides completion but not the capture decided above.
        if (abort) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they are registered yet cycle-aligned with state.
  always_comb begin
    sel_d  = (state_d != ST_APPLY);
    sw_d   = (state_d == ST_APPLY) ? op_idx_d : 4'd0;
    busy_d = (state_d == ST_APPLY);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_idx_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      rd_data_q <= '0;
      sel_q     <= 1'b1;
      sw_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) result_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_idx_q  <= op_idx_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      rd_data_q <= result_q[rd_addr];
      sel_q     <= sel_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (cap_en) result_q[op_idx_q] <= final_output;
    end
  end

  assign select_input = sel_q;
  assign in_switch    = sw_q;
  assign rd_data      = rd_data_q;
  assign valid        = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed multi-cycle scenarios,
// and randomized traffic against a cycle-count based reference model.
module tb_alu_op_sequencer;

  localparam int H = 24;
  localparam int S = 20;
  localparam int N = 15;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  final_output = 4'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic        select_input;
  logic [3:0]  in_switch;
  logic [3:0]  rd_data;
  logic [15:0] valid;
  logic        busy;
  logic        done;

  alu_op_sequencer #(.HOLD_CYCLES(H), .SAMPLE_OFFSET(S), .N_OPS(N)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .final_output(final_output), .rd_addr(rd_addr),
    .select_input(select_input), .in_switch(in_switch), .rd_data(rd_data),
    .valid(valid), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int nerr = 0;
  int nchk = 0;

  // Reference model: mode 0=idle 1=running 2=done; m_e counts cycles since the start edge.
  int          m_mode = 0;
  int          m_e = 0;
  logic [3:0]  m_res [16];
  logic [15:0] m_valid = '0;
  logic [3:0]  m_rd = '0;

  function automatic logic [3:0] cur_op();
    return (m_mode == 1) ? 4'((m_e - 1) / H) : 4'd0;
  endfunction

  function automatic int cur_h();
    return (m_mode == 1) ? (m_e - 1) % H : 0;
  endfunction

  task automatic model_edge();
    int op;
    if (RESET) begin
      m_mode = 0; m_e = 0; m_valid = '0; m_rd = '0;
      for (int i = 0; i < 16; i++) m_res[i] = '0;
    end else begin
      m_rd = m_res[rd_addr];
      case (m_mode)
        0: if (start) begin m_mode = 1; m_e = 1; m_valid = '0; end
        1: begin
          op = (m_e - 1) / H;
          if ((m_e - 1) % H == S) begin
            m_res[op] = final_output;
            m_valid[op] = 1'b1;
          end
          if (abort)            m_mode = 0;
          else if (m_e == N * H) m_mode = 2;
          else                  m_e++;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("select_input", {31'd0, select_input}, {31'd0, m_mode != 1});
    chk("in_switch", {28'd0, in_switch}, {28'd0, cur_op()});
    chk("busy", {31'd0, busy}, {31'd0, m_mode == 1});
    chk("done", {31'd0, done}, {31'd0, m_mode == 2});
    chk("valid", {16'd0, valid}, {16'd0, m_valid});
    chk("rd_data", {28'd0, rd_data}, {28'd0, m_rd});
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_sel"}, {31'd0, select_input}, 32'd1);
    chk({nm, "_sw"}, {28'd0, in_switch}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_valid"}, {16'd0, valid}, 32'd0);
    chk({nm, "_rd"}, {28'd0, rd_data}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        rst, st, ab;
    logic        e_sel, e_busy, e_done;
    logic [3:0]  e_sw;
    logic [15:0] e_valid;
  } vec_t;

  vec_t tv [7];

  // Runs a sequence whose final_output steps 3->C at hold index chg_h of opcode 5, aborting at op 6 / hold 10.
  task automatic sample_run(input int chg_h, input logic [3:0] exp5, input string nm);
    bit aborted = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 400 && !aborted; c++) begin
      final_output = (cur_op() > 5 || (cur_op() == 5 && cur_h() >= chg_h)) ? 4'hC : 4'h3;
      abort = (cur_op() == 6 && cur_h() == 10);
      aborted = abort;
      step();
      abort = 1'b0;
    end
    chk({nm, "_aborted"}, {31'd0, aborted}, 32'd1);
    chk({nm, "_abort_sel"}, {31'd0, select_input}, 32'd1);
    chk({nm, "_abort_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_abort_valid"}, {16'd0, valid}, 32'h003F);
    rd_addr = 4'd5;
    for (int c = 0; c < 3; c++) begin
      step();
      chk({nm, "_no_done"}, {31'd0, done}, 32'd0);
    end
    chk({nm, "_result5"}, {28'd0, rd_data}, {28'd0, exp5});
  endtask

  initial begin
    int done_cnt, done_at;
    bit saw_valid;
    for (int i = 0; i < 16; i++) m_res[i] = '0;

    tv[0] = '{"rst_start",    1, 1, 0, 1, 0, 0, 4'd0, 16'h0};
    tv[1] = '{"rst_dominates", 1, 1, 1, 1, 0, 0, 4'd0, 16'h0};
    tv[2] = '{"abort_idle",   0, 0, 1, 1, 0, 0, 4'd0, 16'h0};
    tv[3] = '{"idle",         0, 0, 0, 1, 0, 0, 4'd0, 16'h0};
    tv[4] = '{"start_wins",   0, 1, 1, 0, 1, 0, 4'd0, 16'h0};
    tv[5] = '{"early_abort",  0, 0, 1, 1, 0, 0, 4'd0, 16'h0};
    tv[6] = '{"rst_again",    1, 0, 0, 1, 0, 0, 4'd0, 16'h0};
    for (int i = 0; i < 7; i++) begin
      RESET = tv[i].rst; start = tv[i].st; abort = tv[i].ab;
      step();
      chk({tv[i].name, "_sel"}, {31'd0, select_input}, {31'd0, tv[i].e_sel});
      chk({tv[i].name, "_busy"}, {31'd0, busy}, {31'd0, tv[i].e_busy});
      chk({tv[i].name, "_done"}, {31'd0, done}, {31'd0, tv[i].e_done});
      chk({tv[i].name, "_sw"}, {28'd0, in_switch}, {28'd0, tv[i].e_sw});
      chk({tv[i].name, "_valid"}, {16'd0, valid}, {16'd0, tv[i].e_valid});
    end
    abort = 1'b0;

    RESET = 1'b1;
    for (int c = 0; c < 25; c++) begin
      start = c[0];
      step();
      chk_reset_outputs("hold_reset");
    end
    RESET = 1'b0; start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("post_reset_sel", {31'd0, select_input}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // Full default run with final_output = ~opcode; start pulses at 50 and 361 must be ignored.
    start = 1'b1; step(); start = 1'b0;
    done_cnt = 0; done_at = -1; saw_valid = 0;
    for (int c = 1; c <= 361; c++) begin
      final_output = ~cur_op();
      start = (c == 50 || c == 361);
      step();
      if (done) begin
        done_cnt++; done_at = c + 1;
        chk("done_valid", {16'd0, valid}, 32'h7FFF);
      end
    end
    start = 1'b0;
    chk("done_count", done_cnt, 32'd1);
    chk("done_cycle", done_at, 32'd361);
    chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {16'd0, valid}, 32'h7FFF);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_valid_clear", {16'd0, valid}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      final_output = ~cur_op();
      rd_addr = 4'(k);
      step();
      chk("readback", {28'd0, rd_data}, (k < 15) ? 32'(15 - k) : 32'd0);
    end

    for (int c = 0; c < 400 && cur_op() != 4'd9; c++) begin
      final_output = ~cur_op();
      step();
    end
    chk("reached_op9", {28'd0, in_switch}, 32'd9);
    RESET = 1'b1; step(); RESET = 1'b0;
    chk_reset_outputs("midrun_reset");
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      step();
      chk("cleared_result", {28'd0, rd_data}, 32'd0);
    end

    sample_run(20, 4'hC, "sample_at20");
    sample_run(21, 4'h3, "sample_at21");

    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 399) == 0);
      final_output = 4'($urandom);
      rd_addr = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
